div_sched: RTL and testbench

- Multi-cycle integer divide sequencer shared by all four divide-class instructions: div.w, mod.w, divu.w, modu.w.
- Sits beside the EX stage. EX hands it a decoded divide op with forwarded operands and stalls until the result handshake completes.
- Owns a single radix-2 restoring divider and sequences it: operand conditioning, 32 iteration steps, sign fix-up, result hold.
- Also handles pipeline flush and the divide-by-zero shortcut.

---
 rtl/div_sched.sv | 111 +++++++++++
 tb/tb_div_sched.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// rtl/div_sched.sv - multi-cycle radix-2 restoring divide sequencer for div.w/mod.w/divu.w/modu.w
module div_sched #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_op,
   input  logic [XLEN-1:0] in_src1,
   input  logic [XLEN-1:0] in_src2,
   input  logic [4:0]      in_dest,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [4:0]      out_dest,
   output logic            busy
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt;
   logic            sgn, want_rem, q_neg, r_neg;
   logic [4:0]      dest;
   logic [XLEN-1:0] src1, src2;
   logic [XLEN-1:0] quo, rem, dvs;
   logic            op_onehot, accept;
   logic [XLEN:0]   rem_sh;
   logic            rem_ge;

   assign op_onehot = (in_op != 4'b0) && ((in_op & (in_op - 4'd1)) == 4'b0);
   assign in_ready  = (state == S_IDLE) && !flush;
   assign accept    = in_valid && in_ready && op_onehot;
   assign busy      = (state != S_IDLE);
   assign out_valid = (state == S_DONE);

   // One extra bit keeps the shifted remainder exact for divisors above 2^(XLEN-1).
   assign rem_sh = {rem, quo[XLEN-1]};
   assign rem_ge = rem_sh >= {1'b0, dvs};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (accept) state_nx = S_PREP;
         S_PREP: state_nx = (src2 == '0) ? S_DONE : S_CALC;
         S_CALC: if (cnt == '0) state_nx = S_FIX;
         S_FIX:  state_nx = S_DONE;
         S_DONE: if (out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (flush) state_nx = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        <= '0;
         sgn        <= 1'b0;
         want_rem   <= 1'b0;
         q_neg      <= 1'b0;
         r_neg      <= 1'b0;
         dest       <= '0;
         src1       <= '0;
         src2       <= '0;
         quo        <= '0;
         rem        <= '0;
         dvs        <= '0;
         out_result <= '0;
         out_dest   <= '0;
      end else if (!flush) begin
         case (state)
            S_IDLE: if (accept) begin
               sgn      <= in_op[3] | in_op[2];
               want_rem <= in_op[2] | in_op[0];
               dest     <= in_dest;
               src1     <= in_src1;
               src2     <= in_src2;
            end
            S_PREP: begin
               quo   <= (sgn && src1[XLEN-1]) ? -src1 : src1;
               dvs   <= (sgn && src2[XLEN-1]) ? -src2 : src2;
               q_neg <= sgn & (src1[XLEN-1] ^ src2[XLEN-1]);
               r_neg <= sgn & src1[XLEN-1];
               rem   <= '0;
               cnt   <= CW'(XLEN - 1);
               if (src2 == '0) begin
                  out_result <= want_rem ? src1 : '1;
                  out_dest   <= dest;
               end
            end
            S_CALC: begin
               rem <= rem_ge ? (rem_sh[XLEN-1:0] - dvs) : rem_sh[XLEN-1:0];
               quo <= {quo[XLEN-2:0], rem_ge};
               cnt <= cnt - 1'b1;
            end
            S_FIX: begin
               out_result <= want_rem ? (r_neg ? -rem : rem) : (q_neg ? -quo : quo);
               out_dest   <= dest;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_div_sched.sv
// tb/tb_div_sched.sv - table-driven self-checking bench for div_sched
module tb_div_sched;
   localparam logic [3:0] OP_DIV  = 4'b1000;
   localparam logic [3:0] OP_MOD  = 4'b0100;
   localparam logic [3:0] OP_DIVU = 4'b0010;
   localparam logic [3:0] OP_MODU = 4'b0001;

   logic        clk, rst;
   logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
   logic [3:0]  in_op;
   logic [31:0] in_src1, in_src2, out_result;
   logic [4:0]  in_dest, out_dest;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  dest;
      logic [31:0] exp;
      int          lat;
      string       name;
   } vec_t;

   vec_t vecs[14];

   div_sched #(.XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_dest(out_dest),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Called on a negedge with the block idle; returns on a negedge after the handshake.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic [31:0] exp, input int lat,
                         input string name);
      int k;
      chk({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_dest = d; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      k = 1;
      while (!out_valid && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (!out_valid) begin
         compared++;
         mismatched++;
         $display("FAIL %s timeout: out_valid never rose within %0d cycles", name, k);
      end else begin
         chk({name, " latency"}, 32'(k), 32'(lat));
         chk({name, " result"}, out_result, exp);
         chk({name, " dest"}, {27'b0, out_dest}, {27'b0, d});
      end
      @(negedge clk);
      chk({name, " valid_drop"}, {31'b0, out_valid}, 32'd0);
      chk({name, " busy_drop"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int   seen;
      logic [31:0] held;

      vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          5'd3,  32'd14,         35, "divu_100_7"};
      vecs[1]  = '{OP_MODU, 32'd100,        32'd7,          5'd4,  32'd2,          35, "modu_100_7"};
      vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd5,  32'hFFFF_FFFD,  35, "div_m7_2"};
      vecs[3]  = '{OP_MOD,  32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  35, "mod_m7_2"};
      vecs[4]  = '{OP_MOD,  32'd7,          32'hFFFF_FFFE,  5'd7,  32'd1,          35, "mod_7_m2"};
      vecs[5]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'h8000_0000,  35, "div_ovf"};
      vecs[6]  = '{OP_MOD,  32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'd0,          35, "mod_ovf"};
      vecs[7]  = '{OP_DIVU, 32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF,  2,  "divu_5_0"};
      vecs[8]  = '{OP_MODU, 32'd5,          32'd0,          5'd11, 32'd5,          2,  "modu_5_0"};
      vecs[9]  = '{OP_DIV,  32'hFFFF_FFF0,  32'd0,          5'd12, 32'hFFFF_FFFF,  2,  "div_m16_0"};
      vecs[10] = '{OP_DIVU, 32'hFFFF_FFFF,  32'h8000_0001,  5'd13, 32'd1,          35, "divu_big"};
      vecs[11] = '{OP_MODU, 32'hFFFF_FFFF,  32'h8000_0001,  5'd14, 32'h7FFF_FFFE,  35, "modu_big"};
      vecs[12] = '{OP_DIV,  32'd100,        32'hFFFF_FFF9,  5'd15, 32'hFFFF_FFF2,  35, "div_100_m7"};
      vecs[13] = '{OP_MOD,  32'hFFFF_FF9C,  32'd7,          5'd31, 32'hFFFF_FFFE,  35, "mod_m100_7"};

      rst = 1'b0; in_valid = 1'b0; in_op = 4'b0; in_src1 = '0; in_src2 = '0;
      in_dest = '0; flush = 1'b0; out_ready = 1'b0;
      #1;
      chk("rst out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst busy", {31'b0, busy}, 32'd0);
      chk("rst out_result", out_result, 32'd0);
      chk("rst out_dest", {27'b0, out_dest}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("idle in_ready", {31'b0, in_ready}, 32'd1);

      for (int i = 0; i < 14; i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].exp, vecs[i].lat, vecs[i].name);

      // flush in the 10th CALC cycle
      in_valid = 1'b1; in_op = OP_DIVU; in_src1 = 32'd1000; in_src2 = 32'd3; in_dest = 5'd20;
      @(posedge clk);
      for (int n = 1; n <= 11; n++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      chk("flush pre busy", {31'b0, busy}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush busy", {31'b0, busy}, 32'd0);
      chk("flush out_valid", {31'b0, out_valid}, 32'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      chk("flush no result", 32'(seen), 32'd0);
      run_op(OP_DIVU, 32'd9, 32'd3, 5'd21, 32'd3, 35, "divu_9_3");

      // in_valid with flush in IDLE, and non-one-hot ops
      in_valid = 1'b1; in_op = OP_DIVU; flush = 1'b1;
      #1 chk("flush idle in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      chk("flush idle no accept", {31'b0, busy}, 32'd0);
      flush = 1'b0; in_op = 4'b0011;
      @(negedge clk);
      chk("bad op 0011", {31'b0, busy}, 32'd0);
      in_op = 4'b0000;
      @(negedge clk);
      chk("bad op 0000", {31'b0, busy}, 32'd0);
      in_valid = 1'b0;

      // flush wins over out_ready in DONE
      in_valid = 1'b1; in_op = OP_DIVU; in_src1 = 32'd5; in_src2 = 32'd0; in_dest = 5'd1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      chk("done before flush", {31'b0, out_valid}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("done flush valid", {31'b0, out_valid}, 32'd0);
      chk("done flush busy", {31'b0, busy}, 32'd0);

      // out_ready held low for 3 cycles in DONE
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = OP_DIVU; in_src1 = 32'd100; in_src2 = 32'd7; in_dest = 5'd18;
      @(posedge clk);
      @(negedge clk); in_valid = 1'b0;
      seen = 1;
      while (!out_valid && seen < 60) begin
         @(negedge clk);
         seen++;
      end
      chk("hold latency", 32'(seen), 32'd35);
      held = out_result;
      chk("hold first result", held, 32'd14);
      in_valid = 1'b1; in_op = OP_MODU; in_src1 = 32'd1; in_src2 = 32'd1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("hold valid", {31'b0, out_valid}, 32'd1);
         chk("hold stable", out_result, 32'd14);
         chk("hold in_ready", {31'b0, in_ready}, 32'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("release valid", {31'b0, out_valid}, 32'd0);
      chk("release in_ready", {31'b0, in_ready}, 32'd1);

      // asynchronous reset in the middle of CALC
      in_valid = 1'b1; in_op = OP_DIV; in_src1 = 32'd77; in_src2 = 32'd5; in_dest = 5'd9;
      @(posedge clk);
      @(negedge clk); in_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async rst out_valid", {31'b0, out_valid}, 32'd0);
      chk("async rst busy", {31'b0, busy}, 32'd0);
      chk("async rst out_result", out_result, 32'd0);
      chk("async rst out_dest", {27'b0, out_dest}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_op(OP_MOD, 32'd77, 32'd5, 5'd2, 32'd2, 35, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
